// File: rtl/flash_op_sequencer.sv
// Sequences WREN / program / erase / RDSR-poll command chains onto the dword interface.
// Owns a small payload FIFO that the host fills before issuing a program request.
module flash_op_sequencer #(
    parameter int unsigned MAX_DW   = 8,
    parameter int unsigned POLL_GAP = 64,
    parameter int unsigned POLL_MAX = 65535
) (
    input  logic        clk_in_i,
    input  logic        reset_i,
    input  logic        req_i,
    input  logic [1:0]  op_i,
    input  logic [23:0] addr_i,
    input  logic        buf_we_i,
    input  logic [31:0] buf_wdata_i,
    output logic [3:0]  buf_count_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [7:0]  status_o,
    output logic        di_wr_o,
    output logic [31:0] di_data_o,
    input  logic        di_busy_i,
    input  logic        di_error_i,
    input  logic [63:0] di_readout_i
);
    localparam int         PW       = (MAX_DW > 1) ? $clog2(MAX_DW) : 1;
    localparam logic [7:0] MAX_C    = 8'(MAX_DW);
    localparam logic [15:0] POLL_LIM = 16'(POLL_MAX);
    localparam logic [7:0] CMD_WREN = 8'h06;
    localparam logic [7:0] CMD_RDSR = 8'h05;

    typedef enum logic [3:0] {
        IDLE, WREN_CMD, WREN_WAIT, OP_CMD, OP_DATA, OP_WAIT,
        POLL_CMD, POLL_WAIT, POLL_IDLE, DONE
    } state_t;

    state_t         state_q, state_d;
    logic [31:0]    mem_q [MAX_DW];
    logic [PW-1:0]  wptr_q, rptr_q;
    logic [7:0]     cnt_q, cnt_eff;
    logic [1:0]     op_q, op_d;
    logic [23:0]    addr_q, addr_d;
    logic [7:0]     len_q, len_d;
    logic [7:0]     left_q, left_d;
    logic           err_q, err_d;
    logic [7:0]     status_q, status_d;
    logic [15:0]    poll_q, poll_d;
    logic [15:0]    gap_q, gap_d;
    logic [7:0]     op_cmd;
    logic           push, pop;
    logic           unused_readout;

    assign unused_readout = ^di_readout_i[63:8];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_DW - 1)) ? '0 : p + 1'b1;
    endfunction

    assign busy_o      = (state_q != IDLE) && (state_q != DONE);
    assign done_o      = (state_q == DONE);
    assign err_o       = err_q;
    assign status_o    = status_q;
    assign buf_count_o = cnt_q[3:0];

    // Host pushes only land while idle; a push in the req cycle counts toward len.
    assign push    = buf_we_i && (cnt_q < MAX_C) && !busy_o;
    assign pop     = (state_q == OP_DATA) && (left_q != len_q);
    assign cnt_eff = cnt_q + {7'd0, push};

    always_comb begin
        op_cmd = 8'hD8;
        case (op_q)
            2'b00:   op_cmd = 8'h02;
            2'b01:   op_cmd = 8'h32;
            default: op_cmd = 8'hD8;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        len_d     = len_q;
        left_d    = left_q;
        err_d     = err_q;
        status_d  = status_q;
        poll_d    = poll_q;
        gap_d     = gap_q;
        di_wr_o   = 1'b0;
        di_data_o = '0;
        case (state_q)
            IDLE: if (req_i) begin
                op_d   = op_i;
                addr_d = addr_i;
                err_d  = 1'b0;
                poll_d = '0;
                len_d  = (op_i == 2'b10) ? 8'd1 : cnt_eff + 8'd1;
                if (!op_i[1] && cnt_eff == 8'd0) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (op_i == 2'b11) begin
                    state_d = POLL_CMD;
                end else begin
                    state_d = WREN_CMD;
                end
            end
            WREN_CMD: if (!di_busy_i) begin
                di_wr_o   = 1'b1;
                di_data_o = {24'd0, CMD_WREN};
                state_d   = WREN_WAIT;
            end
            WREN_WAIT: if (!di_busy_i) begin
                if (di_error_i) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = OP_CMD;
                end
            end
            OP_CMD: if (!di_busy_i) begin
                di_wr_o   = 1'b1;
                di_data_o = {15'd0, op_q == 2'b01, len_q, op_cmd};
                left_d    = len_q;
                state_d   = OP_DATA;
            end
            // Address goes first, then the FIFO drains on back-to-back cycles.
            OP_DATA: begin
                di_wr_o   = 1'b1;
                di_data_o = (left_q == len_q) ? {8'h00, addr_q} : mem_q[rptr_q];
                left_d    = left_q - 8'd1;
                if (left_q == 8'd1) state_d = OP_WAIT;
            end
            OP_WAIT: if (!di_busy_i) begin
                if (di_error_i) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = POLL_CMD;
                end
            end
            POLL_CMD: if (!di_busy_i) begin
                di_wr_o   = 1'b1;
                di_data_o = {24'd0, CMD_RDSR};
                state_d   = POLL_WAIT;
            end
            POLL_WAIT: if (!di_busy_i) begin
                if (di_error_i) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    status_d = di_readout_i[7:0];
                    poll_d   = poll_q + 16'd1;
                    gap_d    = '0;
                    if (op_q == 2'b11 || !di_readout_i[0]) begin
                        state_d = DONE;
                    end else if (poll_d == POLL_LIM) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = POLL_IDLE;
                    end
                end
            end
            POLL_IDLE: begin
                if (32'(gap_q) + 32'd1 >= POLL_GAP) state_d = POLL_CMD;
                else                                gap_d   = gap_q + 16'd1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            op_q     <= 2'b00;
            addr_q   <= '0;
            len_q    <= '0;
            left_q   <= '0;
            err_q    <= 1'b0;
            status_q <= 8'h00;
            poll_q   <= '0;
            gap_q    <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            left_q   <= left_d;
            err_q    <= err_d;
            status_q <= status_d;
            poll_q   <= poll_d;
            gap_q    <= gap_d;
            if (push) wptr_q <= ptr_inc(wptr_q);
            if (pop)  rptr_q <= ptr_inc(rptr_q);
            cnt_q <= cnt_q + {7'd0, push} - {7'd0, pop};
        end
    end

    always_ff @(posedge clk_in_i) begin
        if (push) mem_q[wptr_q] <= buf_wdata_i;
    end
endmodule

// File: doc/flash_op_sequencer.md
Name: flash_op_sequencer

Overview:
- Sequences multi-command SPI flash operations on top of the dword interface: program, quad program, sector erase and status read.
- For program/erase it issues WREN (0x06), then the operation command (address + payload), then polls RDSR (0x05) until WIP clears.
- Holds a small payload FIFO filled by the host side.
- Sits between the host/PC register logic and dword_interface, and is the only driver of that interface's wr/data_from_PC.

Parameters:
- MAX_DW, 8: payload FIFO depth in dwords; legal range 1..(maxcmd/4 - 1).
- POLL_GAP, 64: idle clk_in cycles between consecutive RDSR polls.
- POLL_MAX, 65535: maximum RDSR polls before timeout error; counter is 16 bits.

Ports:
- clk_in  in  1  clock, same as dword_interface.
- reset  in  1  synchronous, active-high.
- req  in  1  start operation; sampled only in IDLE.
- op  in  2  00 program 0x02; 01 quad program 0x32 (quad=1); 10 sector erase 0xD8; 11 status read only.
- addr  in  24  flash byte address.
- buf_we  in  1  push buf_wdata into the payload FIFO.
- buf_wdata  in  32  payload dword.
- buf_count  out  4  dwords currently queued.
- busy  out  1  high from req acceptance until done.
- done  out  1  one-cycle pulse at operation end.
- err  out  1  error flag for the last operation.
- status  out  8  last RDSR byte.
- di_wr  out  1  to dword_interface wr.
- di_data  out  32  to dword_interface data_from_PC.
- di_busy  in  1  from dword_interface busy.
- di_error  in  1  from dword_interface error.
- di_readout  in  64  from dword_interface readout; status byte is [7:0].

Behaviour:
- Reset values:
  - busy=0, done=0, err=0, status=8'h00, di_wr=0, di_data=0.
  - FIFO emptied (buf_count=0), state=IDLE.
  - Reset mid-operation aborts immediately; the in-flight flash command is not cancelled downstream.
- Command word format: {15'b0, quad, len[7:0], cmd[7:0]}. len = number of dwords following.
- Address dword: {8'h00, addr}.
- Issue rule:
  - A command word is driven (di_wr=1) only in a cycle where di_busy=0.
  - Payload dwords are driven on consecutive cycles immediately after it, di_wr=1 each cycle, exactly len cycles.
  - di_wr=0 at all other times.
- Completion rule: after the last word of a command, wait in *_WAIT until di_busy=0; then sample di_error.
  - di_error=1: set err, go to DONE.
- States:
  - IDLE: req=1 → latch op/addr, busy=1.
    - op=00/01 with buf_count=0: err=1, go to DONE; no flash traffic.
    - op=11: go to POLL_CMD, single poll.
    - Otherwise: go to WREN_CMD.
  - WREN_CMD: drive cmd 0x06, len 0 → WREN_WAIT.
  - WREN_WAIT: → OP_CMD.
  - OP_CMD: drive the command word, then go to OP_DATA.
    - Program: len = 1 + buf_count at request time.
    - Erase: len = 1.
  - OP_DATA: drive the address dword, then pop FIFO dwords in order (program only) → OP_WAIT.
  - OP_WAIT: → POLL_CMD.
  - POLL_CMD: drive 0x05, len 0 → POLL_WAIT.
  - POLL_WAIT: on di_busy=0, status ← di_readout[7:0], poll count +1.
    - op=11: go to DONE.
    - status[0]=0: go to DONE.
    - poll count = POLL_MAX: err=1, go to DONE.
    - Otherwise: go to POLL_IDLE.
  - POLL_IDLE: wait POLL_GAP cycles → POLL_CMD.
  - DONE: done=1 for one cycle, busy=0 → IDLE.
- err is cleared when a new req is accepted.
- FIFO:
  - buf_we is ignored when buf_count=MAX_DW or busy=1.
  - Program ops consume the entire FIFO; erase and status ops leave it untouched.
  - Order is first-in first-out.
- Start-up: di_busy stays high after reset until the memory controller is idle. A req accepted in that window waits in WREN_CMD/POLL_CMD; no command is lost.
- Simultaneous req and buf_we in IDLE: the push completes first; the FIFO count used for len includes it.

Test Plan:
- Preload 3 dwords A,B,C; req op=00 addr=0x012340 → di_wr words: 0x00000006; then 0x00000402, 0x00012340, A, B, C on consecutive cycles; then 0x00000005 polls. Model returns status 0x03, 0x03, 0x00 → exactly 3 polls; done pulse; err=0; status=0x00; buf_count=0.
- op=10 addr=0xFF0000 → 0x00000006, then 0x000001D8 followed by 0x00FF0000; FIFO contents unchanged.
- op=01 with 1 dword → command word 0x00010232; quad bit set.
- op=00 with empty FIFO → err=1, done after ≤2 cycles, di_wr never asserted.
- POLL_MAX=4, model status stuck at 0x01 → exactly 4 RDSR commands, err=1. Separately: di_error=1 on the WREN completion → err=1, no further commands.
- FIFO edge cases: push MAX_DW+2 dwords → buf_count=MAX_DW and extra dwords dropped; pushes while busy are ignored; reset asserted during OP_DATA → di_wr=0, busy=0, buf_count=0 on the next cycle.
